pixel_scan_ctrl: RTL and testbench
==================================

PIXEL_SCAN_CTRL -- requirements
Module: pixel_scan_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 32, coordinate width.
REQ-002 Parameter: RGB_SIZE, 24, colour width.
REQ-003 Parameter: SCREEN_WIDTH, 640, pixels per line (>=2).
REQ-004 Parameter: SCREEN_HEIGHT, 480, lines per frame (>=2).
REQ-005 Parameter: GAP_CYCLES, 4, idle cycles between back-to-back frames (>=1).
REQ-006 Ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-007 Ports: start  in  1  begin frame (sampled in IDLE only); stop  in  1  request halt at end of current frame; continuous  in  1  run frames back-to-back.
REQ-008 Ports: col_req  out  1  colour request; col_x, col_y  out  DATA_WIDTH  requested coordinate; col_ack  in  1  colour valid; colour_i  in  RGB_SIZE  renderer colour.
REQ-009 Ports: out_valid  out  1; out_ready  in  1; out_data  out  RGB_SIZE; out_x, out_y  out  DATA_WIDTH; sof, eol, eof  out  1  beat flags.
REQ-010 Ports: busy  out  1  state != IDLE; frame_cnt  out  16  completed frames.

Function
REQ-011 FSM states SHALL be IDLE, REQ, OUT, GAP; all outputs registered.
REQ-012 IDLE: start=1 -> REQ next cycle with col_x=0, col_y=0, col_req=1; start outside IDLE ignored.
REQ-013 REQ: col_req held 1 with stable col_x/col_y until col_ack=1; col_ack while not in REQ ignored.
REQ-014 REQ with col_ack=1 at edge T: capture colour_i into out_data, out_x/out_y=col_x/col_y, out_valid=1, col_req=0 at T+1, state OUT.
REQ-015 Beat flags, valid with out_valid: sof=(x==0&&y==0); eol=(x==SCREEN_WIDTH-1); eof=(x==SCREEN_WIDTH-1&&y==SCREEN_HEIGHT-1).
REQ-016 OUT: beat (data, coords, flags) SHALL stay stable while out_valid&&!out_ready.
REQ-017 OUT handshake (out_ready=1), non-final pixel: out_valid=0 next cycle, state REQ, coordinate advanced: x+1, or x=0,y+1 when x==SCREEN_WIDTH-1.
REQ-018 OUT handshake on eof beat: frame_cnt+1 (wraps 0xFFFF->0); if stop_pending or continuous=0 -> IDLE; else -> GAP.
REQ-019 GAP: counter loads GAP_CYCLES-1 and decrements; at 0 -> REQ with x=0,y=0 (exactly GAP_CYCLES cycles in GAP); stop during GAP -> IDLE next cycle.
REQ-020 stop_pending: set by stop=1 in any non-IDLE state; cleared on entry to IDLE; stop in IDLE without start ignored.
REQ-021 start=1 and stop=1 together in IDLE: frame runs, stop_pending set, exactly one frame then IDLE.
REQ-022 continuous sampled only at eof handshake.
REQ-023 Minimum throughput: one pixel per 2 cycles (col_ack same cycle as col_req first high, out_ready=1).
REQ-024 No pixel skipped or duplicated; each frame emits exactly SCREEN_WIDTH*SCREEN_HEIGHT beats in raster order.

Reset
REQ-025 reset=1 at edge: state IDLE; out_valid, col_req, sof, eol, eof, busy, stop_pending=0; out_data, out_x, out_y, col_x, col_y=0; frame_cnt=0; GAP counter=0.
REQ-026 Reset mid-frame SHALL discard the in-flight beat and request; no out_valid or col_req in the cycle after reset; reset dominates all inputs.

Verification (SCREEN_WIDTH=4, SCREEN_HEIGHT=3, GAP_CYCLES=2)
REQ-027 start pulse, col_ack=1, out_ready=1, continuous=0 -> 12 beats, (0,0) sof=1, (3,0),(3,1) eol=1, (3,2) eol=eof=1, one beat per 2 cycles, then IDLE, frame_cnt=1, busy=0.
REQ-028 out_ready=0 for 5 cycles on beat (2,1) -> out_valid=1 and data/coords constant for 5 cycles; next beat (3,1) only after handshake.
REQ-029 col_ack delayed 3 cycles on (1,0) -> col_req=1, col_x=1, col_y=0 held 3 cycles; captured colour_i equals value at ack edge.
REQ-030 continuous=1, stop pulsed at beat (1,1) of frame 2 -> frame 1 eof handshake, exactly 2 GAP cycles, frame 2 completes fully, then IDLE, frame_cnt=2.
REQ-031 reset during OUT at beat (2,1) with out_ready=0 -> next cycle out_valid=0, col_req=0, frame_cnt=0; new start yields sof beat at (0,0).
REQ-032 start and stop same cycle in IDLE, continuous=1 -> exactly one frame of 12 beats, then IDLE; start asserted mid-frame ignored.

Source files
------------

// File: rtl/pixel_scan_ctrl.sv
// Raster-scan pixel sequencer: requests a colour per coordinate from a renderer
// and forwards each pixel as a flagged ready/valid beat, optionally frame after frame.
module pixel_scan_ctrl #(
   parameter int DATA_WIDTH    = 32,
   parameter int RGB_SIZE      = 24,
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int GAP_CYCLES    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  continuous,
   output logic                  col_req,
   output logic [DATA_WIDTH-1:0] col_x,
   output logic [DATA_WIDTH-1:0] col_y,
   input  logic                  col_ack,
   input  logic [RGB_SIZE-1:0]   colour_i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [RGB_SIZE-1:0]   out_data,
   output logic [DATA_WIDTH-1:0] out_x,
   output logic [DATA_WIDTH-1:0] out_y,
   output logic                  sof,
   output logic                  eol,
   output logic                  eof,
   output logic                  busy,
   output logic [15:0]           frame_cnt
);

   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [GW-1:0]         GAP_LOAD = GW'(GAP_CYCLES - 1);
   localparam logic [DATA_WIDTH-1:0] X_LAST   = DATA_WIDTH'(SCREEN_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] Y_LAST   = DATA_WIDTH'(SCREEN_HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, REQ, OUT, GAP} state_t;

   state_t                state_reg, state_next;
   logic                  col_req_reg, col_req_next;
   logic [DATA_WIDTH-1:0] col_x_reg, col_x_next, col_y_reg, col_y_next;
   logic                  out_valid_reg, out_valid_next;
   logic [RGB_SIZE-1:0]   out_data_reg, out_data_next;
   logic [DATA_WIDTH-1:0] out_x_reg, out_x_next, out_y_reg, out_y_next;
   logic                  sof_reg, sof_next, eol_reg, eol_next, eof_reg, eof_next;
   logic                  busy_reg, busy_next;
   logic [15:0]           frame_cnt_reg, frame_cnt_next;
   logic                  stop_pending_reg, stop_pending_next;
   logic [GW-1:0]         gap_cnt_reg, gap_cnt_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= IDLE;
         col_req_reg      <= 1'b0;
         col_x_reg        <= '0;
         col_y_reg        <= '0;
         out_valid_reg    <= 1'b0;
         out_data_reg     <= '0;
         out_x_reg        <= '0;
         out_y_reg        <= '0;
         sof_reg          <= 1'b0;
         eol_reg          <= 1'b0;
         eof_reg          <= 1'b0;
         busy_reg         <= 1'b0;
         frame_cnt_reg    <= '0;
         stop_pending_reg <= 1'b0;
         gap_cnt_reg      <= '0;
      end else begin
         state_reg        <= state_next;
         col_req_reg      <= col_req_next;
         col_x_reg        <= col_x_next;
         col_y_reg        <= col_y_next;
         out_valid_reg    <= out_valid_next;
         out_data_reg     <= out_data_next;
         out_x_reg        <= out_x_next;
         out_y_reg        <= out_y_next;
         sof_reg          <= sof_next;
         eol_reg          <= eol_next;
         eof_reg          <= eof_next;
         busy_reg         <= busy_next;
         frame_cnt_reg    <= frame_cnt_next;
         stop_pending_reg <= stop_pending_next;
         gap_cnt_reg      <= gap_cnt_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      col_req_next      = col_req_reg;
      col_x_next        = col_x_reg;
      col_y_next        = col_y_reg;
      out_valid_next    = out_valid_reg;
      out_data_next     = out_data_reg;
      out_x_next        = out_x_reg;
      out_y_next        = out_y_reg;
      sof_next          = sof_reg;
      eol_next          = eol_reg;
      eof_next          = eof_reg;
      busy_next         = busy_reg;
      frame_cnt_next    = frame_cnt_reg;
      stop_pending_next = stop_pending_reg;
      gap_cnt_next      = gap_cnt_reg;

      if (state_reg != IDLE && stop)
         stop_pending_next = 1'b1;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next        = REQ;
               col_req_next      = 1'b1;
               col_x_next        = '0;
               col_y_next        = '0;
               busy_next         = 1'b1;
               stop_pending_next = stop;
            end
         end
         REQ: begin
            if (col_ack) begin
               state_next     = OUT;
               col_req_next   = 1'b0;
               out_valid_next = 1'b1;
               out_data_next  = colour_i;
               out_x_next     = col_x_reg;
               out_y_next     = col_y_reg;
               sof_next       = (col_x_reg == '0) && (col_y_reg == '0);
               eol_next       = (col_x_reg == X_LAST);
               eof_next       = (col_x_reg == X_LAST) && (col_y_reg == Y_LAST);
            end
         end
         OUT: begin
            if (out_ready) begin
               out_valid_next = 1'b0;
               sof_next       = 1'b0;
               eol_next       = 1'b0;
               eof_next       = 1'b0;
               if (eof_reg) begin
                  frame_cnt_next = frame_cnt_reg + 16'd1;
                  // a stop arriving on the final handshake counts as pending too
                  if (stop_pending_reg || stop || !continuous) begin
                     state_next        = IDLE;
                     busy_next         = 1'b0;
                     stop_pending_next = 1'b0;
                  end else begin
                     state_next   = GAP;
                     gap_cnt_next = GAP_LOAD;
                  end
               end else begin
                  state_next   = REQ;
                  col_req_next = 1'b1;
                  if (out_x_reg == X_LAST) begin
                     col_x_next = '0;
                     col_y_next = out_y_reg + DATA_WIDTH'(1);
                  end else begin
                     col_x_next = out_x_reg + DATA_WIDTH'(1);
                     col_y_next = out_y_reg;
                  end
               end
            end
         end
         GAP: begin
            if (stop) begin
               state_next        = IDLE;
               busy_next         = 1'b0;
               stop_pending_next = 1'b0;
               gap_cnt_next      = '0;
            end else if (gap_cnt_reg == '0) begin
               state_next   = REQ;
               col_req_next = 1'b1;
               col_x_next   = '0;
               col_y_next   = '0;
            end else begin
               gap_cnt_next = gap_cnt_reg - GW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign col_req   = col_req_reg;
   assign col_x     = col_x_reg;
   assign col_y     = col_y_reg;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_x     = out_x_reg;
   assign out_y     = out_y_reg;
   assign sof       = sof_reg;
   assign eol       = eol_reg;
   assign eof       = eof_reg;
   assign busy      = busy_reg;
   assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Randomised bench for pixel_scan_ctrl on a 4x3 screen with a 2-cycle frame gap;
// a raster-index reference model predicts every beat, handshake and frame count.
module tb_pixel_scan_ctrl;

   localparam int DW   = 32;
   localparam int RGB  = 24;
   localparam int W    = 4;
   localparam int H    = 3;
   localparam int G    = 2;
   localparam int NPIX = W * H;

   logic           clk = 1'b0;
   logic           reset, start, stop, continuous;
   logic           col_req, col_ack, out_valid, out_ready;
   logic           sof, eol, eof, busy;
   logic [DW-1:0]  col_x, col_y, out_x, out_y;
   logic [RGB-1:0] colour_i, out_data;
   logic [15:0]    frame_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_fc = '0;

   always #5 clk = ~clk;

   pixel_scan_ctrl #(
      .DATA_WIDTH(DW), .RGB_SIZE(RGB), .SCREEN_WIDTH(W),
      .SCREEN_HEIGHT(H), .GAP_CYCLES(G)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
      .col_req(col_req), .col_x(col_x), .col_y(col_y), .col_ack(col_ack),
      .colour_i(colour_i), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_x(out_x), .out_y(out_y), .sof(sof), .eol(eol),
      .eof(eof), .busy(busy), .frame_cnt(frame_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one scan session from IDLE until the model says the block is idle again.
   task automatic run_scan(input bit with_stop, input int cont_mode, input int ack_pct,
                           input int rdy_pct, input int stop_frame, input int stop_idx,
                           input int hold_ack_idx, input int hold_rdy_idx, input bit rand_start,
                           output int frames, output int busy_cycles,
                           output int req_len, output int valid_len);
      bit e_req, e_valid, e_busy, pend, stop_sent, done;
      bit p_start, p_stop, p_ack, p_rdy, p_cont;
      logic [RGB-1:0] p_col, e_data;
      logic [2:0] e_flags;
      int k, gap_left, ack_wait, rdy_wait, cyc;
      e_req = 0; e_valid = 0; e_busy = 0; pend = 0; stop_sent = 0; done = 0;
      e_data = '0; k = 0; gap_left = 0; ack_wait = 0; rdy_wait = 0; cyc = 0;
      frames = 0; busy_cycles = 0; req_len = 0; valid_len = 0;
      start      = 1'b1;
      stop       = with_stop;
      continuous = (cont_mode == 1);
      col_ack    = (int'($urandom_range(99)) < ack_pct);
      out_ready  = (int'($urandom_range(99)) < rdy_pct);
      colour_i   = RGB'($urandom);
      while (!done) begin
         p_start = start; p_stop = stop; p_ack = col_ack; p_rdy = out_ready;
         p_cont = continuous; p_col = colour_i;
         tick();
         cyc++;
         if (!e_busy) begin
            if (p_start) begin
               e_busy = 1; e_req = 1; k = 0; pend = p_stop;
            end
         end else begin
            if (p_stop) pend = 1;
            if (e_req) begin
               if (p_ack) begin
                  e_req = 0; e_valid = 1; e_data = p_col;
               end
            end else if (e_valid) begin
               if (p_rdy) begin
                  e_valid = 0;
                  $display("beat frame=%0d x=%0d y=%0d data=%06h", exp_fc, k % W, k / W, e_data);
                  if (k == NPIX - 1) begin
                     exp_fc++; frames++; k = 0;
                     if (pend || !p_cont) begin
                        e_busy = 0; pend = 0;
                     end else begin
                        gap_left = G;
                     end
                  end else begin
                     k++; e_req = 1;
                  end
               end
            end else if (p_stop) begin
               e_busy = 0; pend = 0; gap_left = 0;
            end else if (gap_left == 1) begin
               gap_left = 0; e_req = 1;
            end else begin
               gap_left--;
            end
         end

         if (e_busy) busy_cycles++;
         if (e_req && k == hold_ack_idx) req_len++;
         if (e_valid && k == hold_rdy_idx) valid_len++;
         checks++;
         if ({busy, col_req, out_valid} !== {e_busy, e_req, e_valid}) begin
            errors++;
            $display("FAIL ctrl cyc=%0d: busy/req/valid got %b expected %b",
                     cyc, {busy, col_req, out_valid}, {e_busy, e_req, e_valid});
         end
         checks++;
         if (frame_cnt !== exp_fc) begin
            errors++;
            $display("FAIL frame_cnt cyc=%0d: got %0d expected %0d", cyc, frame_cnt, exp_fc);
         end
         if (e_req) begin
            checks++;
            if (col_x !== DW'(k % W) || col_y !== DW'(k / W)) begin
               errors++;
               $display("FAIL col_coord cyc=%0d: got (%0d,%0d) expected (%0d,%0d)",
                        cyc, col_x, col_y, k % W, k / W);
            end
         end
         if (e_valid) begin
            checks++;
            if (out_data !== e_data || out_x !== DW'(k % W) || out_y !== DW'(k / W)) begin
               errors++;
               $display("FAIL beat cyc=%0d: got %06h (%0d,%0d) expected %06h (%0d,%0d)",
                        cyc, out_data, out_x, out_y, e_data, k % W, k / W);
            end
            e_flags = {(k == 0), (k % W == W - 1), (k == NPIX - 1)};
            checks++;
            if ({sof, eol, eof} !== e_flags) begin
               errors++;
               $display("FAIL flags cyc=%0d: sof/eol/eof got %b expected %b",
                        cyc, {sof, eol, eof}, e_flags);
            end
         end

         done = !e_busy;
         if (!done && cyc >= 4000) begin
            errors++;
            $display("FAIL scan_timeout: still busy after %0d cycles, expected idle", cyc);
            done = 1;
         end
         start = (rand_start && e_busy) ? 1'($urandom_range(1)) : 1'b0;
         stop  = 1'b0;
         if (stop_frame >= 0 && !stop_sent && frames == stop_frame && e_valid && k == stop_idx) begin
            stop = 1'b1; stop_sent = 1;
         end
         if (e_req && k == hold_ack_idx && ack_wait < 3) begin
            col_ack = 1'b0; ack_wait++;
         end else begin
            col_ack = (int'($urandom_range(99)) < ack_pct);
         end
         if (e_valid && k == hold_rdy_idx && rdy_wait < 5) begin
            out_ready = 1'b0; rdy_wait++;
         end else begin
            out_ready = (int'($urandom_range(99)) < rdy_pct);
         end
         if (cont_mode == 2) continuous = 1'($urandom_range(1));
         colour_i = RGB'($urandom);
      end
      start = 1'b0; stop = 1'b0; col_ack = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
      col_ack = 1'b0; out_ready = 1'b0; colour_i = '0;
      repeat (3) tick();
      checks++;
      if ({busy, col_req, out_valid, sof, eol, eof} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000000", {busy, col_req, out_valid, sof, eol, eof});
      end
      checks++;
      if (out_data !== '0 || out_x !== '0 || out_y !== '0 || col_x !== '0 || col_y !== '0 || frame_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_values: data=%h ox=%0d oy=%0d cx=%0d cy=%0d fc=%0d expected all 0",
                  out_data, out_x, out_y, col_x, col_y, frame_cnt);
      end
      reset = 1'b0;
      exp_fc = '0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy got %b expected 0", busy);
      end
   endtask

   task automatic test_single_frame();
      int fr, bc, rl, vl;
      run_scan(0, 0, 100, 100, -1, 0, -1, -1, 0, fr, bc, rl, vl);
      checks++;
      if (fr != 1 || bc != 2 * NPIX) begin
         errors++;
         $display("FAIL single_frame: frames=%0d busy=%0d expected 1 and %0d", fr, bc, 2 * NPIX);
      end
   endtask

   task automatic test_stall_and_ack_delay();
      int fr, bc, rl, vl;
      run_scan(0, 0, 100, 100, -1, 0, 1, 6, 0, fr, bc, rl, vl);
      checks++;
      if (rl != 4) begin
         errors++;
         $display("FAIL ack_delay: col_req high %0d cycles on (1,0), expected 4", rl);
      end
      checks++;
      if (vl != 6) begin
         errors++;
         $display("FAIL ready_stall: out_valid high %0d cycles on (2,1), expected 6", vl);
      end
      checks++;
      if (fr != 1) begin
         errors++;
         $display("FAIL stall_frames: got %0d expected 1", fr);
      end
   endtask

   task automatic test_continuous_stop();
      int fr, bc, rl, vl;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL stop_in_idle: busy got %b expected 0", busy);
      end
      run_scan(0, 1, 70, 70, 1, 5, -1, -1, 0, fr, bc, rl, vl);
      checks++;
      if (fr != 2) begin
         errors++;
         $display("FAIL continuous_stop: frames got %0d expected 2", fr);
      end
   endtask

   task automatic test_start_stop_together();
      int fr, bc, rl, vl;
      run_scan(1, 1, 60, 60, -1, 0, -1, -1, 1, fr, bc, rl, vl);
      checks++;
      if (fr != 1) begin
         errors++;
         $display("FAIL start_with_stop: frames got %0d expected 1", fr);
      end
   endtask

   task automatic test_random_continuous();
      int fr, bc, rl, vl;
      for (int r = 0; r < 3; r++) begin
         run_scan(0, 2, 50, 50, -1, 0, -1, -1, 1, fr, bc, rl, vl);
         checks++;
         if (fr < 1) begin
            errors++;
            $display("FAIL random_run%0d: frames got %0d expected at least 1", r, fr);
         end
      end
   endtask

   task automatic test_back_to_back();
      int fr, bc, rl, vl;
      run_scan(0, 1, 100, 100, 2, 3, -1, -1, 0, fr, bc, rl, vl);
      checks++;
      if (fr != 3 || bc != 3 * 2 * NPIX + 2 * G) begin
         errors++;
         $display("FAIL back_to_back: frames=%0d busy=%0d expected 3 and %0d",
                  fr, bc, 3 * 2 * NPIX + 2 * G);
      end
   endtask

   task automatic test_reset_mid_frame();
      int fr, bc, rl, vl;
      bit found;
      found = 0;
      start = 1'b1; continuous = 1'b0; col_ack = 1'b1; out_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick();
         if (out_valid === 1'b1 && out_x == DW'(2) && out_y == DW'(1)) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL reach_beat_2_1: beat (2,1) not seen, expected within 100 cycles");
      end
      out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b1; start = 1'b1; col_ack = 1'b1; out_ready = 1'b1; stop = 1'b1;
      tick();
      reset = 1'b0; start = 1'b0; stop = 1'b0; col_ack = 1'b0; out_ready = 1'b0;
      exp_fc = '0;
      checks++;
      if ({out_valid, col_req, busy} !== 3'b000 || frame_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid_frame: valid/req/busy=%b fc=%0d expected 000 and 0",
                  {out_valid, col_req, busy}, frame_cnt);
      end
      run_scan(0, 0, 80, 80, -1, 0, -1, -1, 0, fr, bc, rl, vl);
      checks++;
      if (fr != 1) begin
         errors++;
         $display("FAIL after_reset_frame: frames got %0d expected 1", fr);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_stall_and_ack_delay();
      test_continuous_stop();
      test_start_stop_together();
      test_random_continuous();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
